// File: rtl/ml_dsa_pkg.sv
// Shared ML-DSA arithmetic constants and the pointwise-multiplier FSM state type.
// The butterfly, INTT and pointwise stages all import this package.
package ml_dsa_pkg;

    localparam int BIT_LEN = 23;
    localparam int N       = 256;
    localparam int ADDR_W  = 8;
    localparam int CNT_W   = 9;
    localparam int PROD_W  = 2 * BIT_LEN;
    localparam int LAT     = 4;

    localparam logic [BIT_LEN-1:0] Q = BIT_LEN'(8380417);

    // Barrett constant floor(2^46 / Q). With it the quotient estimate is low by at most one.
    localparam int                BARRETT_SHIFT = 46;
    localparam int                QUOT_W        = 24;
    localparam logic [QUOT_W-1:0] BARRETT_M     = QUOT_W'(8396807);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mod_q_barrett.sv
// Two-stage pipelined Barrett reducer: 46-bit product in, fully reduced 23-bit residue out.
// A valid bit travels alongside the data; "active" reports any valid held inside.
module mod_q_barrett
    import ml_dsa_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [PROD_W-1:0]  x,
    output logic               out_valid,
    output logic [BIT_LEN-1:0] r,
    output logic               active
);

    localparam int MUL_W = PROD_W + QUOT_W;
    localparam int QQ_W  = QUOT_W + BIT_LEN;
    localparam int REM_W = BIT_LEN + 2;
    localparam logic [REM_W-1:0] Q_R = REM_W'(Q);

    logic [MUL_W-1:0]  xm;
    logic [QUOT_W-1:0] quot;
    logic [QUOT_W-1:0] s3_quot;
    logic [PROD_W-1:0] s3_x;
    logic              s3_valid;
    logic [QQ_W-1:0]   qq;
    logic [PROD_W-1:0] diff;
    logic [REM_W-1:0]  rem0;
    logic [REM_W-1:0]  rem1;
    logic [REM_W-1:0]  rem2;

    assign xm   = MUL_W'(x) * MUL_W'(BARRETT_M);
    assign quot = QUOT_W'(xm >> BARRETT_SHIFT);

    // The true remainder is below 3Q < 2^25, so only the low 25 bits of the difference matter.
    assign qq   = QQ_W'(s3_quot) * QQ_W'(Q);
    assign diff = s3_x - PROD_W'(qq);
    assign rem0 = REM_W'(diff);
    assign rem1 = (rem0 >= Q_R) ? rem0 - Q_R : rem0;
    assign rem2 = (rem1 >= Q_R) ? rem1 - Q_R : rem1;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_valid  <= 1'b0;
            s3_x      <= '0;
            s3_quot   <= '0;
            out_valid <= 1'b0;
            r         <= '0;
        end else begin
            s3_valid  <= in_valid;
            s3_x      <= x;
            s3_quot   <= quot;
            out_valid <= s3_valid;
            r         <= BIT_LEN'(rem2);
        end
    end

    assign active = s3_valid | out_valid;

endmodule

// File: rtl/ntt_pointwise_mul.sv
// Pointwise NTT-domain multiply: a (stream) times b (sync-read memory), reduced mod Q.
// Fixed four-edge latency, one coefficient per cycle, done pulse after the 256th result.
module ntt_pointwise_mul
    import ml_dsa_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [ADDR_W-1:0]  in_addr,
    input  logic [BIT_LEN-1:0] in_data,
    output logic [ADDR_W-1:0]  b_addr,
    input  logic [BIT_LEN-1:0] b_rdata,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_addr,
    output logic [BIT_LEN-1:0] out_data,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   acc_cnt;
    logic [CNT_W-1:0]   acc_cnt_nxt;
    logic               err_nxt;
    logic               accept;
    logic               pipe_empty;

    logic               s1_valid;
    logic [BIT_LEN-1:0] s1_a;
    logic [ADDR_W-1:0]  s1_addr;
    logic               s2_valid;
    logic [PROD_W-1:0]  s2_prod;
    logic [ADDR_W-1:0]  s2_addr;
    logic [ADDR_W-1:0]  s3_addr;
    logic [ADDR_W-1:0]  s4_addr;
    logic               red_valid;
    logic [BIT_LEN-1:0] red_data;
    logic               red_active;

    // The memory registers this address on the same edge that stage 1 captures a.
    assign b_addr = in_addr;

    mod_q_barrett u_reduce (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s2_valid),
        .x         (s2_prod),
        .out_valid (red_valid),
        .r         (red_data),
        .active    (red_active)
    );

    assign pipe_empty = !(s1_valid || s2_valid || red_active);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        acc_cnt_nxt = acc_cnt;
        err_nxt     = err;
        accept      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    accept      = 1'b1;
                    acc_cnt_nxt = CNT_W'(1);
                    err_nxt     = 1'b0;
                    state_nxt   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    accept      = 1'b1;
                    acc_cnt_nxt = acc_cnt + 1'b1;
                    if (acc_cnt == CNT_W'(N - 1)) state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (in_valid)   err_nxt   = 1'b1;
                if (pipe_empty) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (in_valid) err_nxt = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            acc_cnt <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc_cnt <= acc_cnt_nxt;
            err     <= err_nxt;
        end
    end

    // Output register keeps the result stream launched directly from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_addr   <= '0;
            s2_valid  <= 1'b0;
            s2_prod   <= '0;
            s2_addr   <= '0;
            s3_addr   <= '0;
            s4_addr   <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            s1_valid  <= accept;
            s1_a      <= in_data;
            s1_addr   <= in_addr;
            s2_valid  <= s1_valid;
            s2_prod   <= PROD_W'(s1_a) * PROD_W'(b_rdata);
            s2_addr   <= s1_addr;
            s3_addr   <= s2_addr;
            s4_addr   <= s3_addr;
            out_valid <= red_valid;
            out_addr  <= s4_addr;
            out_data  <= red_data;
        end
    end

    assign busy = (state == ST_RUN) || (state == ST_FLUSH);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_ntt_pointwise_mul.sv
// Directed bench for ntt_pointwise_mul: latency, corner residues, full/gapped streams,
// overrun error flag and asynchronous reset in mid-stream.
module tb_ntt_pointwise_mul;

    localparam longint QM = 8380417;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_addr;
    logic [22:0] in_data;
    logic [7:0]  b_addr;
    logic [22:0] b_rdata = '0;
    logic        out_valid;
    logic [7:0]  out_addr;
    logic [22:0] out_data;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [22:0] b_mem [256];
    int          cyc = 0;

    logic [7:0]  got_addr [$];
    logic [22:0] got_data [$];
    int          got_cyc  [$];
    logic [7:0]  exp_addr [$];
    logic [22:0] exp_data [$];
    int          exp_cyc  [$];
    int          n_done    = 0;
    int          done_cyc  = 0;
    int          n_overlap = 0;

    ntt_pointwise_mul dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .b_addr    (b_addr),
        .b_rdata   (b_rdata),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        b_rdata <= b_mem[b_addr];
    end

    always @(negedge clk) begin
        if (out_valid) begin
            got_addr.push_back(out_addr);
            got_data.push_back(out_data);
            got_cyc.push_back(cyc);
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (done && out_valid) n_overlap++;
    end

    function automatic logic [22:0] mulmod(input longint a, input longint b);
        longint p;
        p = (a * b) % QM;
        return p[22:0];
    endfunction

    task automatic clear_mon();
        got_addr.delete(); got_data.delete(); got_cyc.delete();
        exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
        n_done = 0; done_cyc = 0; n_overlap = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
        #2 clear_mon();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one coefficient for one cycle; its result is due at the negedge after edge +4.
    task automatic send(input logic [22:0] a, input logic [7:0] addr,
                        input logic [22:0] expv, input bit expect_out);
        in_valid = 1'b1; in_addr = addr; in_data = a;
        if (expect_out) begin
            exp_addr.push_back(addr);
            exp_data.push_back(expv);
            exp_cyc.push_back(cyc + 5);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && n_done == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic stream_errors(output int errs);
        errs = 0;
        if (got_data.size() != exp_data.size()) errs++;
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++)
            if (got_data[i] !== exp_data[i] || got_addr[i] !== exp_addr[i] || got_cyc[i] !== exp_cyc[i])
                errs++;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
        for (int i = 0; i < 256; i++) b_mem[i] = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (out_addr !== 8'd0) $display("FAIL reset_out_addr: got %0d want 0", out_addr); else n_pass++;
        n_checks++; if (out_data !== 23'd0) $display("FAIL reset_out_data: got %0d want 0", out_data); else n_pass++;
        n_checks++; if ({busy, done, err} !== 3'b000) $display("FAIL reset_flags: got busy/done/err=%b want 000", {busy, done, err}); else n_pass++;
        n_checks++; if (b_addr !== 8'd0) $display("FAIL reset_b_addr: got %0d want 0", b_addr); else n_pass++;
        reset = 1'b0;
        clear_mon();
    endtask

    task automatic test_single();
        do_reset();
        b_mem[5] = 23'd3;
        in_valid = 1'b1; in_addr = 8'd5; in_data = 23'd2;
        #1;
        n_checks++; if (b_addr !== 8'd5) $display("FAIL single_b_addr: got %0d want 5", b_addr); else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %0b want 1", busy); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_early: out_valid got %0b want 0 at edge +3", out_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %0b want 1 at edge +4", out_valid); else n_pass++;
        n_checks++; if (out_addr !== 8'd5) $display("FAIL single_addr: got %0d want 5", out_addr); else n_pass++;
        n_checks++; if (out_data !== 23'd6) $display("FAIL single_data: got %0d want 6", out_data); else n_pass++;
        @(negedge clk);
        n_checks++; if ({out_valid, done} !== 2'b00) $display("FAIL single_after: got valid/done=%b want 00", {out_valid, done}); else n_pass++;
    endtask

    task automatic test_corner();
        logic [22:0] hand [4];
        hand = '{23'd1, 23'd8380415, 23'd16382, 23'd32764};
        do_reset();
        b_mem[0] = 23'd8380416; b_mem[1] = 23'd2; b_mem[2] = 23'd4; b_mem[3] = 23'd8388607;
        send(23'd8380416, 8'd0, hand[0], 1'b1);
        send(23'd8380416, 8'd1, hand[1], 1'b1);
        send(23'd4194304, 8'd2, hand[2], 1'b1);
        send(23'd8388607, 8'd3, hand[3], 1'b1);
        repeat (8) @(negedge clk);
        n_checks++; if (got_data.size() != 4) $display("FAIL corner_count: got %0d want 4", got_data.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= got_data.size()) $display("FAIL corner_%0d: no output want %0d", i, hand[i]);
            else if (got_data[i] !== hand[i]) $display("FAIL corner_%0d: got %0d want %0d", i, got_data[i], hand[i]);
            else n_pass++;
        end
    endtask

    task automatic test_full_poly();
        int errs;
        do_reset();
        for (int i = 0; i < 256; i++) b_mem[i] = 23'(i);
        for (int i = 0; i < 256; i++) send(23'(i), 8'(i), mulmod(i, i), 1'b1);
        wait_done(50);
        stream_errors(errs);
        n_checks++; if (errs != 0) $display("FAIL full_stream: got %0d bad entries (%0d outputs) want 0 of 256", errs, got_data.size()); else n_pass++;
        n_checks++; if (n_done != 1) $display("FAIL full_done_count: got %0d want 1", n_done); else n_pass++;
        n_checks++; if (done_cyc != exp_cyc[255] + 1) $display("FAIL full_done_time: got cycle %0d want %0d", done_cyc, exp_cyc[255] + 1); else n_pass++;
        n_checks++; if (n_overlap != 0) $display("FAIL full_overlap: got %0d want 0", n_overlap); else n_pass++;
        n_checks++; if ({busy, err} !== 2'b00) $display("FAIL full_idle: got busy/err=%b want 00", {busy, err}); else n_pass++;
    endtask

    task automatic test_gapped();
        int          errs;
        logic [7:0]  addr;
        logic [22:0] a;
        do_reset();
        for (int i = 0; i < 256; i++) b_mem[i] = 23'(longint'(i) * 40961 + 1234567);
        for (int i = 0; i < 256; i++) begin
            addr = 8'(i * 37);
            a    = 23'(longint'(255 - i) * 65599 + 7777777);
            send(a, addr, mulmod(a, b_mem[addr]), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_done(50);
        stream_errors(errs);
        n_checks++; if (errs != 0) $display("FAIL gapped_stream: got %0d bad entries (%0d outputs) want 0", errs, got_data.size()); else n_pass++;
        n_checks++; if (n_done != 1) $display("FAIL gapped_done_count: got %0d want 1", n_done); else n_pass++;
        n_checks++; if (done_cyc != exp_cyc[255] + 1) $display("FAIL gapped_done_time: got cycle %0d want %0d", done_cyc, exp_cyc[255] + 1); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL gapped_err: got %0b want 0", err); else n_pass++;
    endtask

    task automatic test_overrun();
        int errs;
        do_reset();
        for (int i = 0; i < 256; i++) b_mem[i] = 23'(i + 1);
        for (int i = 0; i < 256; i++) send(23'(i + 1000), 8'(i), mulmod(i + 1000, i + 1), 1'b1);
        send(23'd4242, 8'd0, 23'd0, 1'b0);
        n_checks++; if (err !== 1'b1) $display("FAIL overrun_err_set: got %0b want 1", err); else n_pass++;
        wait_done(50);
        stream_errors(errs);
        n_checks++; if (errs != 0 || got_data.size() != 256) $display("FAIL overrun_stream: got %0d bad, %0d outputs want 0 bad, 256", errs, got_data.size()); else n_pass++;
        n_checks++; if (n_done != 1) $display("FAIL overrun_done_count: got %0d want 1", n_done); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL overrun_err_sticky: got %0b want 1", err); else n_pass++;
        send(23'd7, 8'd9, mulmod(7, 10), 1'b1);
        n_checks++; if ({busy, err} !== 2'b10) $display("FAIL overrun_err_clear: got busy/err=%b want 10", {busy, err}); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int errs;
        do_reset();
        for (int i = 0; i < 256; i++) b_mem[i] = 23'(i * 3 + 1);
        for (int i = 0; i < 100; i++) send(23'(i + 5), 8'(i), mulmod(i + 5, i * 3 + 1), 1'b1);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL midrst_active: out_valid got %0b want 1", out_valid); else n_pass++;
        reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
        #1;
        n_checks++;
        if ({out_valid, busy, done, err} !== 4'b0000 || out_addr !== 8'd0 || out_data !== 23'd0 || b_addr !== 8'd0)
            $display("FAIL midrst_outputs: got v/b/d/e=%b addr=%0d data=%0d b_addr=%0d want all 0",
                     {out_valid, busy, done, err}, out_addr, out_data, b_addr);
        else n_pass++;
        clear_mon();
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (n_done != 0 || got_data.size() != 0) $display("FAIL midrst_flushed: got done=%0d outputs=%0d want 0 0", n_done, got_data.size()); else n_pass++;
        for (int i = 0; i < 256; i++) send(23'(8388607 - i), 8'(255 - i), mulmod(8388607 - i, (255 - i) * 3 + 1), 1'b1);
        wait_done(50);
        stream_errors(errs);
        n_checks++; if (errs != 0) $display("FAIL midrst_stream: got %0d bad entries (%0d outputs) want 0", errs, got_data.size()); else n_pass++;
        n_checks++; if (n_done != 1) $display("FAIL midrst_done_count: got %0d want 1", n_done); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_corner();
        test_full_poly();
        test_gapped();
        test_overrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ntt_pointwise_mul.md
Name: ntt_pointwise_mul

Overview:
- Streaming stage directly downstream of the forward NTT.
- Consumes the NTT's 256-coefficient write-out stream (valid/addr/data).
- Multiplies each coefficient by the matching NTT-domain coefficient of a second polynomial, read from an external synchronous RAM/ROM. Reduces the product fully mod q = 8380417.
- Emits the result stream with address for the inverse-NTT input buffer. Pulses done after coefficient 255 is out.

Parameters:
- BIT_LEN, 23, coefficient width.
- N, 256, coefficients per polynomial.
- Q, 8380417, ML-DSA modulus.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  coefficient present (driven by the NTT write strobe).
- in_addr  in  8  coefficient index.
- in_data  in  BIT_LEN  coefficient a, any 23-bit value.
- b_addr  out  8  read address to B-poly memory.
- b_rdata  in  BIT_LEN  B coefficient; valid 1 cycle after b_addr (synchronous read).
- out_valid  out  1  result present.
- out_addr  out  8  index of result.
- out_data  out  BIT_LEN  (a*b) mod Q, in [0, Q-1].
- busy  out  1  high in RUN/FLUSH.
- done  out  1  one-cycle pulse, polynomial complete.
- err  out  1  sticky: in_valid seen during FLUSH/DONE.

Behaviour:
- Reset (async, active-high): state IDLE, counters 0, pipeline valids cleared. Outputs out_valid=0, out_addr=0, out_data=0, done=0, busy=0, err=0, b_addr=0. A reset mid-stream discards all in-flight data; no done is produced.
- Datapath: combinational b_addr = in_addr. Fixed latency LAT = 4 edges: the in_valid sampled at edge E produces out_valid at edge E+4.
  - Pipeline stage 1: register a, addr, valid.
  - Stage 2: 46-bit product a*b_rdata.
  - Stage 3: Barrett quotient estimate.
  - Stage 4: subtract q*quot, then up to two conditional subtracts of Q.
  - Result must be exactly the product mod Q for every 23-bit a, b (product < 2^46).
- Throughput: one coefficient per cycle, back-to-back, no stalls. There is no backpressure; gaps in in_valid are allowed and propagate as gaps in out_valid.
- FSM:
  - IDLE: first in_valid → RUN. That coefficient is accepted and counted; acc_cnt=1 and err is cleared.
  - RUN: each in_valid increments acc_cnt. When the 256th is accepted → FLUSH.
  - FLUSH: wait until all pipeline valids are 0 → DONE. in_valid here is ignored (not processed) and sets err.
  - DONE: done=1 for exactly one cycle, then → IDLE. in_valid here is ignored and sets err.
- done timing: the 256th out_valid occurs at edge E+4. done is high during the cycle following it, never overlapping out_valid.
- in_addr is passed through unchanged. Duplicate or out-of-order addresses are not checked; only the count matters.
- acc_cnt is 9 bits, so no wrap-around at 255.
- busy = (state == RUN || state == FLUSH).

Decomposition:
- Shared package ml_dsa_pkg: Q, N, BIT_LEN, Barrett constant (floor(2^46/Q)) and shift, LAT.
- Sub-module mod_q_barrett: 2-stage pipelined 46→23-bit reducer with valid pass-through, reusable by the butterfly and INTT.
- Multiplier stage and FSM stay in ntt_pointwise_mul.

Test Plan:
- Single coefficient: a=2, addr=5, b=3 → out_valid at edge +4, out_addr=5, out_data=6, busy=1.
- Corner values: a=8380416, b=8380416 → 1; a=8380416, b=2 → 8380415; a=4194304, b=4 → 16382; a=8388607, b=8388607 → reference-model value.
- Full polynomial: 256 back-to-back in_valid, a=i, b=i → 256 consecutive out_valid with (i*i) mod Q, then done one cycle after the last, busy low after done.
- Gapped stream: in_valid toggled 1/0 random, 256 accepted total → outputs match, same gaps, single done, err=0.
- Overrun: 257 coefficients → 257th ignored, err=1 until the next polynomial's first in_valid, exactly 256 out_valid.
- Reset mid-stream: assert reset after 100 coefficients → all outputs 0 immediately (asynchronous). A fresh 256 stream then completes normally with one done.
